// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch port between the PC sequencer and memory.
// The sequencer drives the request and address; memory returns ack/data.
interface pc_sequencer_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/commit controller: owns the architectural PC, fetches, waits for
// execution, commits next_pc, and traps on misalignment or fetch timeout.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int          TIMEOUT  = 16,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   pc_sequencer_if.master   imem,
   output logic [31:0]      instr,
   output logic             instr_valid,
   input  logic             exec_done,
   input  logic [31:0]      next_pc,
   output logic [31:0]      pc,
   input  logic             halt_req,
   input  logic             resume,
   output logic             halted,
   output logic             err_misalign,
   output logic             err_timeout,
   output logic [31:0]      err_addr,
   output logic [CNT_W-1:0] retired_cnt
);

   localparam logic [1:0] S_BOOT  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_EXEC  = 2'd2;
   localparam logic [1:0] S_HALT  = 2'd3;

   localparam int            WW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WW-1:0] WLIM = WW'(TIMEOUT - 1);

   logic [1:0]    state;
   logic [WW-1:0] wait_cnt;

   // Request and address decode straight from state and pc.
   assign imem.imem_req  = (state == S_FETCH);
   assign imem.imem_addr = pc;

   // Sequencer state, PC, captured instruction, flags and retire count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_BOOT;
         pc           <= RESET_PC;
         instr        <= '0;
         instr_valid  <= 1'b0;
         halted       <= 1'b0;
         err_misalign <= 1'b0;
         err_timeout  <= 1'b0;
         err_addr     <= '0;
         retired_cnt  <= '0;
         wait_cnt     <= '0;
      end else begin
         unique case (state)
            S_BOOT: begin
               state <= S_FETCH;
            end
            S_FETCH: begin
               if (imem.imem_ack) begin
                  instr       <= imem.imem_rdata;
                  wait_cnt    <= '0;
                  instr_valid <= 1'b1;
                  state       <= S_EXEC;
               end else if (wait_cnt == WLIM) begin
                  err_timeout <= 1'b1;
                  err_addr    <= pc;
                  wait_cnt    <= '0;
                  halted      <= 1'b1;
                  state       <= S_HALT;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_EXEC: begin
               if (exec_done) begin
                  instr_valid <= 1'b0;
                  if (next_pc[1:0] != 2'b00) begin
                     err_misalign <= 1'b1;
                     err_addr     <= next_pc;
                     halted       <= 1'b1;
                     state        <= S_HALT;
                  end else begin
                     pc          <= next_pc;
                     retired_cnt <= retired_cnt + CNT_W'(1);
                     if (halt_req) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                     end else begin
                        state <= S_FETCH;
                     end
                  end
               end
            end
            S_HALT: begin
               if (resume && !err_misalign && !err_timeout) begin
                  halted <= 1'b0;
                  state  <= S_FETCH;
               end
            end
            default: begin
               state <= S_BOOT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with queue-based exec/halt scoreboards.
// A second instance with TIMEOUT=4 and no memory covers fetch timeout.
module tb_pc_sequencer;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] cnt;
   } exec_t;

   typedef struct packed {
      logic [31:0] pc;
      logic        mis;
      logic        to;
      logic [31:0] addr;
      logic [31:0] cnt;
   } halt_t;

   logic clk;
   logic rst_n;
   logic rst1_n;

   pc_sequencer_if bus0 ();
   pc_sequencer_if bus1 ();

   logic [31:0] instr, next_pc, pc, err_addr, retired_cnt;
   logic        instr_valid, exec_done, halt_req, resume;
   logic        halted, err_misalign, err_timeout;

   logic [31:0] instr1, next_pc1, pc1, err_addr1, retired_cnt1;
   logic        instr_valid1, exec_done1, halt_req1, resume1;
   logic        halted1, err_misalign1, err_timeout1;

   exec_t exec_q[$];
   halt_t halt_q[$];
   halt_t halt1_q[$];

   int n_chk  = 0;
   int n_pass = 0;

   pc_sequencer u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem         (bus0.master),
      .instr        (instr),
      .instr_valid  (instr_valid),
      .exec_done    (exec_done),
      .next_pc      (next_pc),
      .pc           (pc),
      .halt_req     (halt_req),
      .resume       (resume),
      .halted       (halted),
      .err_misalign (err_misalign),
      .err_timeout  (err_timeout),
      .err_addr     (err_addr),
      .retired_cnt  (retired_cnt)
   );

   pc_sequencer #(.TIMEOUT(4)) u_dut1 (
      .clk          (clk),
      .rst_n        (rst1_n),
      .imem         (bus1.master),
      .instr        (instr1),
      .instr_valid  (instr_valid1),
      .exec_done    (exec_done1),
      .next_pc      (next_pc1),
      .pc           (pc1),
      .halt_req     (halt_req1),
      .resume       (resume1),
      .halted       (halted1),
      .err_misalign (err_misalign1),
      .err_timeout  (err_timeout1),
      .err_addr     (err_addr1),
      .retired_cnt  (retired_cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h", nm, act, exp);
   endtask

   // exec scoreboard: one record per entry into EXEC
   initial begin : mon_exec
      logic  pv;
      exec_t e;
      pv = 1'b0;
      forever begin
         @(negedge clk);
         if (instr_valid && !pv) begin
            if (exec_q.size() == 0) begin
               chk("exec_unexpected", exec_q.size(), 1);
            end else begin
               e = exec_q.pop_front();
               chk("exec_pc", pc, e.pc);
               chk("exec_instr", instr, e.instr);
               chk("exec_cnt", retired_cnt, e.cnt);
            end
         end
         pv = instr_valid;
      end
   end

   // halt scoreboard for the main instance
   initial begin : mon_halt
      logic  ph;
      halt_t h;
      ph = 1'b0;
      forever begin
         @(negedge clk);
         if (halted && !ph) begin
            if (halt_q.size() == 0) begin
               chk("halt_unexpected", halt_q.size(), 1);
            end else begin
               h = halt_q.pop_front();
               chk("halt_pc", pc, h.pc);
               chk("halt_mis", {31'd0, err_misalign}, {31'd0, h.mis});
               chk("halt_to", {31'd0, err_timeout}, {31'd0, h.to});
               chk("halt_addr", err_addr, h.addr);
               chk("halt_cnt", retired_cnt, h.cnt);
               chk("halt_req_low", {31'd0, bus0.imem_req}, 32'd0);
            end
         end
         ph = halted;
      end
   end

   // halt scoreboard for the timeout instance
   initial begin : mon_halt1
      logic  ph;
      halt_t h;
      ph = 1'b0;
      forever begin
         @(negedge clk);
         if (halted1 && !ph) begin
            if (halt1_q.size() == 0) begin
               chk("halt1_unexpected", halt1_q.size(), 1);
            end else begin
               h = halt1_q.pop_front();
               chk("halt1_pc", pc1, h.pc);
               chk("halt1_mis", {31'd0, err_misalign1}, {31'd0, h.mis});
               chk("halt1_to", {31'd0, err_timeout1}, {31'd0, h.to});
               chk("halt1_addr", err_addr1, h.addr);
               chk("halt1_cnt", retired_cnt1, h.cnt);
            end
         end
         ph = halted1;
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      bus0.imem_ack = 1'b0;
      exec_done = 1'b0;
      halt_req = 1'b0;
      resume = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_pc", pc, 32'h3000);
      chk("rst_instr", instr, 32'h0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_errs", {30'd0, err_misalign, err_timeout}, 32'd0);
      chk("rst_err_addr", err_addr, 32'h0);
      chk("rst_cnt", retired_cnt, 32'h0);
      chk("rst_req", {31'd0, bus0.imem_req}, 32'd0);
      rst_n = 1'b1;
   endtask

   task automatic wait_req();
      int n;
      n = 0;
      while (!bus0.imem_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("wait_req", {31'd0, bus0.imem_req}, 32'd1);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin : stim
      int n;
      int k;
      int held;
      rst_n = 1'b0;
      rst1_n = 1'b0;
      bus0.imem_ack = 1'b0;
      bus0.imem_rdata = '0;
      bus1.imem_ack = 1'b0;
      bus1.imem_rdata = '0;
      exec_done = 1'b0;
      next_pc = '0;
      halt_req = 1'b0;
      resume = 1'b0;
      exec_done1 = 1'b0;
      next_pc1 = '0;
      halt_req1 = 1'b0;
      resume1 = 1'b0;

      // reset state of main instance, release both
      do_reset();
      rst1_n = 1'b1;
      halt1_q.push_back('{pc: 32'h3000, mis: 1'b0, to: 1'b1,
                          addr: 32'h3000, cnt: 32'd0});

      // timeout instance: 4 fetch cycles then halt, resume ignored
      @(negedge clk);
      n = 0;
      k = 0;
      while (!halted1 && k < 20) begin
         if (bus1.imem_req) n++;
         @(negedge clk);
         k++;
      end
      chk("to_cycles", n, 4);
      resume1 = 1'b1;
      repeat (2) @(negedge clk);
      resume1 = 1'b0;
      chk("to_resume_halted", {31'd0, halted1}, 32'd1);
      chk("to_resume_req", {31'd0, bus1.imem_req}, 32'd0);
      chk("to_sticky", {31'd0, err_timeout1}, 32'd1);

      // 1-cycle ack, 1-cycle done
      wait_req();
      chk("t1_addr", bus0.imem_addr, 32'h3000);
      bus0.imem_ack = 1'b1;
      bus0.imem_rdata = 32'h2008_0005;
      exec_q.push_back('{pc: 32'h3000, instr: 32'h2008_0005, cnt: 32'd0});
      @(negedge clk);
      bus0.imem_ack = 1'b0;
      bus0.imem_rdata = '0;
      chk("t1_valid_hi", {31'd0, instr_valid}, 32'd1);
      exec_done = 1'b1;
      next_pc = 32'h3004;
      @(negedge clk);
      exec_done = 1'b0;
      chk("t1_valid_lo", {31'd0, instr_valid}, 32'd0);
      chk("t1_pc", pc, 32'h3004);
      chk("t1_cnt", retired_cnt, 32'd1);
      chk("t1_req", {31'd0, bus0.imem_req}, 32'd1);
      chk("t1_addr2", bus0.imem_addr, 32'h3004);

      // ack after 5 waits, then misaligned target
      do_reset();
      wait_req();
      held = 0;
      for (int i = 0; i < 5; i++) begin
         if (bus0.imem_req && bus0.imem_addr == 32'h3000) held++;
         @(negedge clk);
      end
      if (bus0.imem_req && bus0.imem_addr == 32'h3000) held++;
      chk("t2_hold", held, 6);
      chk("t2_instr_pre", instr, 32'h0);
      bus0.imem_ack = 1'b1;
      bus0.imem_rdata = 32'h00A0_0013;
      exec_q.push_back('{pc: 32'h3000, instr: 32'h00A0_0013, cnt: 32'd0});
      @(negedge clk);
      bus0.imem_ack = 1'b0;
      exec_done = 1'b1;
      next_pc = 32'h3002;
      halt_q.push_back('{pc: 32'h3000, mis: 1'b1, to: 1'b0,
                         addr: 32'h3002, cnt: 32'd0});
      @(negedge clk);
      exec_done = 1'b0;
      resume = 1'b1;
      bus0.imem_ack = 1'b1;
      bus0.imem_rdata = 32'hDEAD_BEEF;
      repeat (2) @(negedge clk);
      resume = 1'b0;
      bus0.imem_ack = 1'b0;
      chk("t2_halted", {31'd0, halted}, 32'd1);
      chk("t2_req", {31'd0, bus0.imem_req}, 32'd0);
      chk("t2_pc", pc, 32'h3000);
      chk("t2_stray_ack", instr, 32'h00A0_0013);

      // halt_req at commit, then resume (with halt_req) refetches
      do_reset();
      wait_req();
      bus0.imem_ack = 1'b1;
      bus0.imem_rdata = 32'h1234_5678;
      exec_q.push_back('{pc: 32'h3000, instr: 32'h1234_5678, cnt: 32'd0});
      @(negedge clk);
      bus0.imem_ack = 1'b0;
      exec_done = 1'b1;
      next_pc = 32'h3010;
      halt_req = 1'b1;
      halt_q.push_back('{pc: 32'h3010, mis: 1'b0, to: 1'b0,
                         addr: 32'h0, cnt: 32'd1});
      @(negedge clk);
      exec_done = 1'b0;
      @(negedge clk);
      chk("t3_still_halted", {31'd0, halted}, 32'd1);
      resume = 1'b1;
      @(negedge clk);
      resume = 1'b0;
      halt_req = 1'b0;
      chk("t3_req", {31'd0, bus0.imem_req}, 32'd1);
      chk("t3_addr", bus0.imem_addr, 32'h3010);
      chk("t3_unhalt", {31'd0, halted}, 32'd0);
      bus0.imem_ack = 1'b1;
      bus0.imem_rdata = 32'hABCD_0001;
      exec_q.push_back('{pc: 32'h3010, instr: 32'hABCD_0001, cnt: 32'd1});
      @(negedge clk);
      bus0.imem_ack = 1'b0;
      exec_done = 1'b1;
      next_pc = 32'h3014;
      @(negedge clk);
      exec_done = 1'b0;
      chk("t3_pc", pc, 32'h3014);
      chk("t3_cnt", retired_cnt, 32'd2);

      // reset during EXEC with exec_done: no commit
      bus0.imem_ack = 1'b1;
      bus0.imem_rdata = 32'h0000_0011;
      exec_q.push_back('{pc: 32'h3014, instr: 32'h0000_0011, cnt: 32'd2});
      @(negedge clk);
      bus0.imem_ack = 1'b0;
      exec_done = 1'b1;
      next_pc = 32'h3018;
      rst_n = 1'b0;
      #1;
      chk("t4_async_pc", pc, 32'h3000);
      chk("t4_async_valid", {31'd0, instr_valid}, 32'd0);
      @(negedge clk);
      exec_done = 1'b0;
      chk("t4_pc", pc, 32'h3000);
      chk("t4_cnt", retired_cnt, 32'd0);
      chk("t4_req", {31'd0, bus0.imem_req}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t4_refetch", {31'd0, bus0.imem_req}, 32'd1);
      chk("t4_addr", bus0.imem_addr, 32'h3000);

      repeat (2) @(negedge clk);
      chk("exec_q_empty", exec_q.size(), 0);
      chk("halt_q_empty", halt_q.size(), 0);
      chk("halt1_q_empty", halt1_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
